// File: rtl/ascon_buf_pkg.sv
// Shared state type, tag sizing and byte-count helper for the ASCON stream buffer.
package ascon_buf_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, DONE} state_t;

  localparam int TAG_W     = 128;
  localparam int TAG_BYTES = 16;

  function automatic int total_bytes(input int count, input int block_w,
                                     input int byte_w, input bit with_tag);
    return count * (block_w / byte_w) + (with_tag ? TAG_BYTES : 0);
  endfunction

endpackage

// File: rtl/ascon_byte_tx.sv
// One-byte LD/TxBusy handshake with uart_core; a new send in WAIT_LO chains
// straight into the next LOAD without passing through IDLE.
module ascon_byte_tx
  import ascon_buf_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              init_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              send_i,
  input  logic              tx_busy_i,
  output logic [BYTE_W-1:0] tx_byte_o,
  output logic              tx_ld_o,
  output logic              byte_done_o
);

  state_t st;

  assign byte_done_o = (st == WAIT_LO) && !tx_busy_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st        <= IDLE;
      tx_byte_o <= '0;
      tx_ld_o   <= 1'b0;
    end else if (init_i) begin
      st        <= IDLE;
      tx_byte_o <= '0;
      tx_ld_o   <= 1'b0;
    end else begin
      tx_ld_o <= 1'b0;
      case (st)
        IDLE: begin
          if (send_i) begin
            tx_byte_o <= byte_i;
            tx_ld_o   <= 1'b1;
            st        <= LOAD;
          end
        end
        LOAD: st <= WAIT_HI;
        WAIT_HI: begin
          if (tx_busy_i) st <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy_i) begin
            if (send_i) begin
              tx_byte_o <= byte_i;
              tx_ld_o   <= 1'b1;
              st        <= LOAD;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ascon_stream_buf.sv
// Cipher word buffer with a flat parallel view and an autonomous byte streamer
// into uart_core. Optional tag append: define ASCON_BUF_TAG_APPEND_EN.
module ascon_stream_buf
  import ascon_buf_pkg::*;
#(
  parameter int NBLOCKS = 23,
  parameter int BLOCK_W = 64,
  parameter int BYTE_W  = 8
) (
  input  logic                         clock_i,
  input  logic                         resetb_i,
  input  logic                         init_i,
  input  logic                         wr_en_i,
  input  logic [BLOCK_W-1:0]           wr_data_i,
  input  logic                         start_tx_i,
`ifdef ASCON_BUF_TAG_APPEND_EN
  input  logic [TAG_W-1:0]             tag_i,
`endif
  input  logic                         tx_busy_i,
  output logic [BYTE_W-1:0]            tx_byte_o,
  output logic                         tx_ld_o,
  output logic [NBLOCKS*BLOCK_W-1:0]   wave_o,
  output logic [$clog2(NBLOCKS+1)-1:0] count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);

  localparam int WAVE_W = NBLOCKS * BLOCK_W;
  localparam int BPW    = BLOCK_W / BYTE_W;
  localparam int NBYTES = NBLOCKS * BPW;
  localparam int CNT_W  = $clog2(NBLOCKS + 1);
`ifdef ASCON_BUF_TAG_APPEND_EN
  localparam bit WITH_TAG = 1'b1;
`else
  localparam bit WITH_TAG = 1'b0;
`endif
  localparam int MAX_BYTES = NBYTES + (WITH_TAG ? TAG_BYTES : 0);
  localparam int PTR_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  logic [BLOCK_W-1:0] mem [NBLOCKS];
  state_t             st;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   nptr;
  logic [BYTE_W-1:0]  next_byte;
  logic               send;
  logic               byte_done;
  logic               last;
  int                 total;
`ifdef ASCON_BUF_TAG_APPEND_EN
  logic [TAG_W-1:0]   tag_q;
`endif

  // Byte p of the stream is byte p of wave_o counted from the MSB end.
  function automatic logic [BYTE_W-1:0] data_byte(input logic [WAVE_W-1:0] w, input int p);
    logic [WAVE_W-1:0] s;
    s = w >> ((NBYTES - 1 - p) * BYTE_W);
    return s[BYTE_W-1:0];
  endfunction

`ifdef ASCON_BUF_TAG_APPEND_EN
  function automatic logic [BYTE_W-1:0] tag_byte(input logic [TAG_W-1:0] t, input int k);
    logic [TAG_W-1:0] s;
    s = t >> ((TAG_BYTES - 1 - k) * BYTE_W);
    return s[BYTE_W-1:0];
  endfunction
`endif

  for (genvar i = 0; i < NBLOCKS; i++) begin : g_wave
    assign wave_o[(NBLOCKS-i)*BLOCK_W-1 -: BLOCK_W] = mem[i];
  end

  assign full_o  = (count_o == CNT_W'(NBLOCKS));
  assign empty_o = (count_o == '0);
  assign total   = total_bytes(int'(count_o), BLOCK_W, BYTE_W, WITH_TAG);
  assign last    = (int'(ptr) == total - 1);

  // The sender latches next_byte when send fires, so the mux looks one byte ahead.
  always_comb begin
    nptr      = (st == IDLE) ? '0 : ptr + PTR_W'(1);
    next_byte = data_byte(wave_o, int'(nptr));
`ifdef ASCON_BUF_TAG_APPEND_EN
    if (int'(nptr) >= int'(count_o) * BPW)
      next_byte = tag_byte((st == IDLE) ? tag_i : tag_q, int'(nptr) - int'(count_o) * BPW);
`endif
    send = 1'b0;
    if (st == IDLE)      send = start_tx_i && (total > 0);
    else if (st == LOAD) send = byte_done && !last;
  end

  // LOAD here spans the whole per-byte handshake run by ascon_byte_tx.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      for (int i = 0; i < NBLOCKS; i++) mem[i] <= '0;
      count_o    <= '0;
      st         <= IDLE;
      ptr        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
`ifdef ASCON_BUF_TAG_APPEND_EN
      tag_q      <= '0;
`endif
    end else if (init_i) begin
      for (int i = 0; i < NBLOCKS; i++) mem[i] <= '0;
      count_o    <= '0;
      st         <= IDLE;
      ptr        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (wr_en_i) begin
        if (st == IDLE && !full_o) begin
          for (int i = 0; i < NBLOCKS; i++)
            if (i == int'(count_o)) mem[i] <= wr_data_i;
          count_o <= count_o + CNT_W'(1);
        end else begin
          overflow_o <= 1'b1;
        end
      end
      case (st)
        IDLE: begin
          if (start_tx_i) begin
            busy_o <= 1'b1;
            ptr    <= '0;
            st     <= (total > 0) ? LOAD : DONE;
`ifdef ASCON_BUF_TAG_APPEND_EN
            tag_q  <= tag_i;
`endif
          end
        end
        LOAD: begin
          if (byte_done) begin
            if (last) st  <= DONE;
            else      ptr <= nptr;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  ascon_byte_tx #(.BYTE_W(BYTE_W)) u_tx (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .init_i      (init_i),
    .byte_i      (next_byte),
    .send_i      (send),
    .tx_busy_i   (tx_busy_i),
    .tx_byte_o   (tx_byte_o),
    .tx_ld_o     (tx_ld_o),
    .byte_done_o (byte_done)
  );

endmodule

// File: tb/tb_ascon_stream_buf.sv
// Self-checking bench for ascon_stream_buf: word queue reference model plus a
// uart_core busy model that holds TxBusy for busy_len cycles after each LD.
module tb_ascon_stream_buf;
  localparam int NBLOCKS = 23;
  localparam int BLOCK_W = 64;
  localparam int BYTE_W  = 8;
  localparam int WAVE_W  = NBLOCKS * BLOCK_W;
  localparam int BPW     = BLOCK_W / BYTE_W;
  localparam int CNT_W   = $clog2(NBLOCKS + 1);

  logic clk = 1'b0, rst_n = 1'b0, init = 1'b0, wr_en = 1'b0, start_tx = 1'b0;
  logic tx_busy = 1'b0;
  logic [BLOCK_W-1:0] wr_data = '0;
  logic [BYTE_W-1:0]  tx_byte;
  logic               tx_ld, full, empty, busy, done, overflow;
  logic [WAVE_W-1:0]  wave;
  logic [CNT_W-1:0]   count;

  int total = 0, bad = 0;

  ascon_stream_buf #(.NBLOCKS(NBLOCKS), .BLOCK_W(BLOCK_W), .BYTE_W(BYTE_W)) dut (
    .clock_i(clk), .resetb_i(rst_n), .init_i(init), .wr_en_i(wr_en),
    .wr_data_i(wr_data), .start_tx_i(start_tx), .tx_busy_i(tx_busy),
    .tx_byte_o(tx_byte), .tx_ld_o(tx_ld), .wave_o(wave), .count_o(count),
    .full_o(full), .empty_o(empty), .busy_o(busy), .done_o(done),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // uart_core stand-in
  int busy_len = 10;
  int busy_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end else if (tx_ld) begin
      busy_cnt <= busy_len;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  logic [BYTE_W-1:0] got[$];
  int ld_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (tx_ld === 1'b1) begin
      got.push_back(tx_byte);
      ld_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  end

  // Reference model: stored words in order, sticky overflow flag.
  logic [BLOCK_W-1:0] q_words[$];
  bit                 m_ovf = 1'b0;
  logic [BYTE_W-1:0]  exp_q[$];

  function automatic logic [WAVE_W-1:0] model_wave();
    logic [WAVE_W-1:0] w;
    w = '0;
    foreach (q_words[i]) w[WAVE_W-1-i*BLOCK_W -: BLOCK_W] = q_words[i];
    return w;
  endfunction

  task automatic build_exp();
    logic [BLOCK_W-1:0] w;
    exp_q.delete();
    foreach (q_words[i]) begin
      w = q_words[i];
      for (int k = 0; k < BPW; k++) exp_q.push_back(w[BLOCK_W-1-k*BYTE_W -: BYTE_W]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q_words.delete();
    m_ovf = 1'b0;
  endtask

  task automatic write_word(input logic [BLOCK_W-1:0] w, input bit blocked);
    @(negedge clk);
    wr_en = 1'b1; wr_data = w;
    @(negedge clk);
    wr_en = 1'b0;
    if (blocked || q_words.size() == NBLOCKS) m_ovf = 1'b1;
    else q_words.push_back(w);
  endtask

  task automatic pulse_init();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    q_words.delete();
    m_ovf = 1'b0;
  endtask

  task automatic start_stream();
    @(negedge clk); start_tx = 1'b1;
    @(negedge clk); start_tx = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({count, empty, full, tx_ld, busy, done, overflow} !== {CNT_W'(0), 6'b100000}) begin
      bad++; $display("FAIL reset_flags got cnt=%0d e=%b f=%b ld=%b b=%b d=%b o=%b", count, empty, full, tx_ld, busy, done, overflow);
    end
    total++;
    if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_byte got %h want 00", tx_byte); end
    total++;
    if (wave !== '0) begin bad++; $display("FAIL reset_wave not zero"); end
  endtask

  task automatic test_fill();
    logic [WAVE_W-1:0] saved;
    for (int i = 1; i <= NBLOCKS; i++) write_word(BLOCK_W'(i), 1'b0);
    total++;
    if (full !== 1'b1 || count !== CNT_W'(NBLOCKS)) begin bad++; $display("FAIL fill_full got full=%b count=%0d want 1 23", full, count); end
    total++;
    if (wave[WAVE_W-1 -: BLOCK_W] !== 64'h1) begin bad++; $display("FAIL fill_word0 got %h want 1", wave[WAVE_W-1 -: BLOCK_W]); end
    total++;
    if (wave[BLOCK_W-1:0] !== 64'h17) begin bad++; $display("FAIL fill_word22 got %h want 17", wave[BLOCK_W-1:0]); end
    total++;
    if (wave !== model_wave()) begin bad++; $display("FAIL fill_wave differs from model"); end
    saved = wave;
    write_word(64'hDEAD, 1'b0);
    total++;
    if (overflow !== m_ovf || overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got %b want 1", overflow); end
    total++;
    if (wave !== saved || count !== CNT_W'(NBLOCKS)) begin bad++; $display("FAIL overflow_keep wave changed or count=%0d", count); end
  endtask

  task automatic test_init_with_write();
    @(negedge clk); init = 1'b1; wr_en = 1'b1; wr_data = 64'h55;
    @(negedge clk); init = 1'b0; wr_en = 1'b0;
    q_words.delete(); m_ovf = 1'b0;
    total++;
    if (count !== '0 || overflow !== 1'b0 || empty !== 1'b1 || wave !== '0) begin
      bad++; $display("FAIL init_vs_write got count=%0d ovf=%b empty=%b", count, overflow, empty);
    end
  endtask

  task automatic test_known_stream();
    bit ok; int ld0, d0, nbad;
    write_word(64'h0123456789ABCDEF, 1'b0);
    write_word(64'hFEDCBA9876543210, 1'b0);
    build_exp();
    busy_len = 10; got.delete(); ld0 = ld_cnt; d0 = done_cnt;
    start_stream();
    total++;
    if (tx_ld !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL first_ld_latency got ld=%b busy=%b want 1 1", tx_ld, busy); end
    wait_done(1000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL known_done timeout"); end
    @(negedge clk);
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    total++;
    if (nbad != 0 || got.size() != 16 || ld_cnt - ld0 != 16) begin
      bad++; $display("FAIL known_bytes got %0d bytes (%0d wrong) want 16", got.size(), nbad);
    end
    total++;
    if (done_cnt - d0 != 1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL known_done_pulse got pulses=%0d done=%b busy=%b", done_cnt - d0, done, busy);
    end
    total++;
    if (tx_byte !== 8'h10) begin bad++; $display("FAIL byte_hold got %h want 10", tx_byte); end
  endtask

  task automatic test_resend();
    bit ok; int nbad;
    got.delete();
    start_stream();
    wait_done(1000, ok);
    @(negedge clk);
    nbad = 0;
    foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
    total++;
    if (!ok || nbad != 0 || got.size() != exp_q.size()) begin
      bad++; $display("FAIL resend got %0d bytes (%0d wrong) done=%b want %0d", got.size(), nbad, ok, exp_q.size());
    end
  endtask

  task automatic test_empty_start();
    int ld0;
    pulse_init();
    ld0 = ld_cnt;
    start_stream();
    total++;
    if (done !== 1'b0 || tx_ld !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL empty_cycle1 got done=%b ld=%b busy=%b want 0 0 1", done, tx_ld, busy); end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL empty_done got done=%b busy=%b want 1 0", done, busy); end
    repeat (5) @(negedge clk);
    total++;
    if (ld_cnt != ld0) begin bad++; $display("FAIL empty_no_ld got %0d loads want 0", ld_cnt - ld0); end
  endtask

  task automatic test_init_mid_stream();
    int n, ld0, d0;
    logic [BLOCK_W-1:0] w;
    write_word({$urandom, $urandom}, 1'b0);
    write_word({$urandom, $urandom}, 1'b0);
    busy_len = 10;
    start_stream();
    n = (tx_ld === 1'b1) ? 1 : 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (tx_ld === 1'b1) n++;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL init_mid_reach got %0d loads want 4", n); end
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    q_words.delete(); m_ovf = 1'b0;
    total++;
    if (count !== '0 || busy !== 1'b0 || tx_ld !== 1'b0) begin bad++; $display("FAIL init_mid_clear got count=%0d busy=%b ld=%b", count, busy, tx_ld); end
    ld0 = ld_cnt; d0 = done_cnt;
    repeat (40) @(negedge clk);
    total++;
    if (ld_cnt != ld0 || done_cnt != d0) begin bad++; $display("FAIL init_mid_quiet got loads=%0d dones=%0d want 0 0", ld_cnt - ld0, done_cnt - d0); end
    w = {$urandom, $urandom};
    write_word(w, 1'b0);
    total++;
    if (wave[WAVE_W-1 -: BLOCK_W] !== w || count !== CNT_W'(1)) begin bad++; $display("FAIL init_mid_write got %h count=%0d want %h 1", wave[WAVE_W-1 -: BLOCK_W], count, w); end
  endtask

  task automatic test_reset_mid_stream();
    int n;
    pulse_init();
    write_word({$urandom, $urandom}, 1'b0);
    write_word({$urandom, $urandom}, 1'b0);
    busy_len = 10;
    start_stream();
    n = (tx_ld === 1'b1) ? 1 : 0;
    for (int i = 0; i < 400 && n < 6; i++) begin
      @(negedge clk);
      if (tx_ld === 1'b1) n++;
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({count, empty, full, tx_ld, busy, done, overflow} !== {CNT_W'(0), 6'b100000} || wave !== '0 || tx_byte !== 8'h00) begin
      bad++; $display("FAIL reset_mid got loads_seen=%0d cnt=%0d ld=%b busy=%b byte=%h", n, count, tx_ld, busy, tx_byte);
    end
    @(negedge clk); rst_n = 1'b1;
    q_words.delete(); m_ovf = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int n, nbad;
    for (int it = 0; it < 4; it++) begin
      pulse_init();
      n = $urandom_range(1, 6);
      busy_len = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) write_word({$urandom, $urandom}, 1'b0);
      build_exp();
      got.delete();
      start_stream();
      if (it % 2 == 1) write_word({$urandom, $urandom}, 1'b1);
      wait_done(3000, ok);
      @(negedge clk);
      nbad = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
      total++;
      if (!ok || nbad != 0 || got.size() != exp_q.size()) begin
        bad++; $display("FAIL random_stream it=%0d got %0d bytes (%0d wrong) want %0d", it, got.size(), nbad, exp_q.size());
      end
      total++;
      if (count !== CNT_W'(q_words.size()) || overflow !== m_ovf || wave !== model_wave()) begin
        bad++; $display("FAIL random_state it=%0d got count=%0d ovf=%b want %0d %b", it, count, overflow, q_words.size(), m_ovf);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_init_with_write();
    test_known_stream();
    test_resend();
    test_empty_start();
    test_init_mid_stream();
    test_reset_mid_stream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_stream_buf.md
Name: ascon_stream_buf

Overview:
- Parametrised successor to the fixed 23x64-bit cipher register.
- Stores up to NBLOCKS words of BLOCK_W bits from the ASCON core.
- Exposes the stored words as a flat parallel bus for the existing UART FSM.
- Can also drain the buffer autonomously, byte by byte, into uart_core through the LD/TxBusy handshake. The UART FSM then no longer has to slice the 1472-bit wave itself.

Parameters:
- NBLOCKS, 23, number of BLOCK_W words stored (≥1).
- BLOCK_W, 64, width of one cipher word. Must be a multiple of BYTE_W.
- BYTE_W, 8, UART byte width.

Ports:
- clock_i  in  1  main clock (50 MHz domain).
- resetb_i  in  1  asynchronous reset, active low.
- init_i  in  1  synchronous clear of buffer, counters and flags.
- wr_en_i  in  1  write strobe for one word.
- wr_data_i  in  BLOCK_W  cipher word.
- start_tx_i  in  1  single-cycle request to stream the buffer contents.
- tx_busy_i  in  1  TxBusy from uart_core.
- tx_byte_o  out  BYTE_W  byte to uart_core Din.
- tx_ld_o  out  1  one-cycle load strobe to uart_core LD.
- wave_o  out  NBLOCKS*BLOCK_W  parallel view; word 0 in the MSBs.
- count_o  out  $clog2(NBLOCKS+1)  number of stored words.
- full_o  out  1  count_o==NBLOCKS.
- empty_o  out  1  count_o==0.
- busy_o  out  1  high while streaming.
- done_o  out  1  one-cycle pulse when streaming completes.
- overflow_o  out  1  sticky: a write was dropped.

Behaviour:
- Reset (resetb_i low, async): all storage 0, count_o 0, empty_o 1, full_o 0, tx_ld_o 0, tx_byte_o 0, busy_o 0, done_o 0, overflow_o 0, FSM in IDLE.
- Storage: array of NBLOCKS words, write pointer = count_o.
  - wave_o word i occupies bits [(NBLOCKS-i)*BLOCK_W-1 -: BLOCK_W].
  - Unwritten words read 0.
- Write: in IDLE with wr_en_i=1 and !full_o, word[count] <= wr_data_i and count increments. Visible on wave_o and count_o the next cycle.
- Write while full_o, or while busy_o: data dropped, count unchanged, overflow_o set. overflow_o is cleared only by init_i or reset.
- init_i: highest priority in every state. Next cycle: storage 0, count 0, flags 0, FSM IDLE, tx_ld_o 0. If init_i and wr_en_i arrive together, init wins and the write is lost without setting overflow_o.
- FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO, DONE.
  - IDLE: on start_tx_i → LOAD with byte pointer 0 and busy_o 1. If empty_o, go to DONE instead; no byte is sent.
  - LOAD: tx_byte_o = byte[ptr], tx_ld_o 1 for exactly one cycle → WAIT_HI.
  - WAIT_HI: wait for tx_busy_i=1 → WAIT_LO.
  - WAIT_LO: wait for tx_busy_i=0.
    - If ptr == count*BLOCK_W/BYTE_W-1 → DONE.
    - Otherwise ptr++ → LOAD.
  - DONE: done_o 1 for one cycle, busy_o 0 → IDLE. Contents are kept, so a second start_tx_i resends the same data.
- Byte order: word 0 first, MSB byte of each word first. Byte k of word w is wr_data[BLOCK_W-1-k*BYTE_W -: BYTE_W].
- tx_byte_o holds its value from LOAD until the next LOAD.
- start_tx_i outside IDLE is ignored.
- Pointer widths: $clog2(NBLOCKS*BLOCK_W/BYTE_W) bits. There is no wrap-around; the terminal compare uses count_o, not NBLOCKS.
- Latency: from start_tx_i to the first tx_ld_o is 1 cycle.

Optional Feature:
- Macro: ASCON_BUF_TAG_APPEND_EN.
- When defined:
  - Adds input tag_i (128 bits), sampled at start_tx_i.
  - After the last data byte, the FSM streams 16 tag bytes, MSB first, with the same LOAD/WAIT_HI/WAIT_LO handshake. done_o then fires after the tag.
  - An empty buffer sends the tag only.
- When undefined: no tag_i port; behaviour exactly as above.

Decomposition:
- Package ascon_buf_pkg:
  - State enum type (IDLE, LOAD, WAIT_HI, WAIT_LO, DONE).
  - TAG_W=128 and TAG_BYTES=16.
  - Function computing total byte count.
- Sub-module ascon_byte_tx: owns the LOAD/WAIT_HI/WAIT_LO handshake with uart_core.
  - Inputs: byte_i, send_i.
  - Outputs: tx_byte_o, tx_ld_o, byte_done_o.
  - The parent owns the pointer, storage and IDLE/DONE.

Test Plan:
- Reset mid-stream: assert resetb_i low during WAIT_LO of byte 5 → all outputs at reset values immediately; tx_ld_o 0, count_o 0.
- Fill 23 words 0x0001..0x0017 → full_o 1, count_o 23. wave_o[1471:1408]=0x...0001 and wave_o[63:0]=0x...0017.
- 24th write 0xDEAD → overflow_o 1, wave_o unchanged.
- 2 words 0x0123456789ABCDEF, 0xFEDCBA9876543210, then start_tx, with a busy model of 10 cycles per byte → exactly 16 tx_ld_o pulses. Bytes 01,23,…,EF,FE,…,10; then a done_o pulse; busy_o low afterwards.
- start_tx_i with empty buffer → no tx_ld_o, done_o pulse 2 cycles after the request.
- init_i asserted in WAIT_HI of byte 3 → next cycle IDLE, count_o 0, no further tx_ld_o, no done_o. A write then lands in word 0.
